// File: rtl/noc_vc_pkg.sv
// Shared types and defaults for per-port output VC bookkeeping.
package noc_vc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_t;

  localparam int CN_DEFAULT    = 5;
  localparam int DEPTH_DEFAULT = 4;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Saturating credit counter for one downstream VC buffer; resets to a full buffer.
module vc_credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_send,
  input  logic          i_return,
  output logic [CW-1:0] o_credit_next,
  output logic          o_nonzero,
  output logic          o_underflow,
  output logic          o_overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_credit;

  // A send and a return in the same cycle cancel, so only the lone cases move the count.
  always_comb begin
    o_credit_next = r_credit;
    o_underflow   = i_send && (r_credit == '0);
    o_overflow    = i_return && !i_send && (r_credit == FULL);
    if (i_send && !i_return && (r_credit != '0)) begin
      o_credit_next = r_credit - 1'b1;
    end else if (i_return && !i_send && (r_credit != FULL)) begin
      o_credit_next = r_credit + 1'b1;
    end
  end

  assign o_nonzero = (r_credit != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_credit <= FULL;
    end else begin
      r_credit <= o_credit_next;
    end
  end

endmodule

// File: rtl/output_vc_state_ctrl.sv
// Output-port VC availability tracker: IDLE/ACTIVE/DRAIN per VC, credit
// accounting, free-VC count and a sticky protocol-error flag.
module output_vc_state_ctrl
  import noc_vc_pkg::*;
#(
  parameter int CN    = CN_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = credit_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CN-1:0]            outVCAvailableReset,
  input  logic [CN-1:0]            flitSent,
  input  logic [CN-1:0]            tailSent,
  input  logic [CN-1:0]            creditIn,
  output logic [CN-1:0]            outVCAvailable,
  output logic [CN-1:0]            outVCCredit,
  output logic [$clog2(CN+1)-1:0]  freeVCCount,
  output logic                     protoErr
);

  localparam int FW = $clog2(CN + 1);

  vc_state_t     r_state      [CN];
  vc_state_t     w_state_next [CN];
  logic [CW-1:0] w_credit_next [CN];
  logic [CN-1:0] w_nonzero;
  logic [CN-1:0] w_underflow;
  logic [CN-1:0] w_overflow;
  logic [CN-1:0] w_idle_next;
  logic [FW-1:0] w_free_next;
  logic [FW-1:0] r_free_count;
  logic          w_err;
  logic          r_proto_err;

  for (genvar gi = 0; gi < CN; gi++) begin : g_vc
    vc_credit_counter #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_credit (
      .clk           (clk),
      .rstn          (rstn),
      .i_send        (flitSent[gi]),
      .i_return      (creditIn[gi]),
      .o_credit_next (w_credit_next[gi]),
      .o_nonzero     (w_nonzero[gi]),
      .o_underflow   (w_underflow[gi]),
      .o_overflow    (w_overflow[gi])
    );

    assign outVCAvailable[gi] = (r_state[gi] == IDLE);
  end

  always_comb begin
    w_err       = |w_underflow || |w_overflow || ((flitSent & (flitSent - 1'b1)) != '0);
    w_idle_next = '0;
    w_free_next = '0;
    for (int i = 0; i < CN; i++) begin
      w_state_next[i] = r_state[i];
      case (r_state[i])
        IDLE:    if (outVCAvailableReset[i]) w_state_next[i] = ACTIVE;
        ACTIVE:  if (flitSent[i] && tailSent[i]) w_state_next[i] = DRAIN;
        // Free only once this cycle's update leaves the downstream buffer empty.
        DRAIN:   if (w_credit_next[i] == CW'(DEPTH)) w_state_next[i] = IDLE;
        default: w_state_next[i] = IDLE;
      endcase
      if (flitSent[i] && (r_state[i] == IDLE))            w_err = 1'b1;
      if (tailSent[i] && !flitSent[i])                    w_err = 1'b1;
      if (outVCAvailableReset[i] && (r_state[i] != IDLE)) w_err = 1'b1;
      w_idle_next[i] = (w_state_next[i] == IDLE);
      w_free_next    = w_free_next + FW'(w_idle_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CN; i++) r_state[i] <= IDLE;
      r_free_count <= FW'(CN);
      r_proto_err  <= 1'b0;
    end else begin
      for (int i = 0; i < CN; i++) r_state[i] <= w_state_next[i];
      r_free_count <= w_free_next;
      r_proto_err  <= r_proto_err | w_err;
    end
  end

  assign outVCCredit = w_nonzero;
  assign freeVCCount = r_free_count;
  assign protoErr    = r_proto_err;

endmodule
